// File: rtl/ioctl_loader_pkg.sv
// ioctl_loader_pkg
//   Shared definitions for the HPS ioctl loader: FSM state encoding, ioctl
//   index codes, ROM region encodings and the ROM region map.
//   The region map is contiguous from download address 0. Each entry gives
//   the download start address, the region size and the memory base address.
package ioctl_loader_pkg;

  localparam int IOCTL_AW = 27;

  localparam logic [15:0] INDEX_ROM   = 16'd0;
  localparam logic [15:0] INDEX_DIPSW = 16'd254;

  localparam logic [1:0] REGION_MAIN  = 2'd0;
  localparam logic [1:0] REGION_SOUND = 2'd1;
  localparam logic [1:0] REGION_GFX   = 2'd2;
  localparam logic [1:0] REGION_PROM  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ROM_DL    = 3'd1,
    ST_ROM_ISSUE = 3'd2,  // latched byte decoded, request being issued
    ST_MEM_WAIT  = 3'd3,
    ST_WAIT_HOLD = 3'd4,  // ack seen, WAIT still held to the HPS
    ST_DONE      = 3'd5,
    ST_DIP_DL    = 3'd6
  } state_e;

  typedef struct packed {
    logic [IOCTL_AW-1:0] start;
    logic [IOCTL_AW-1:0] size;
    logic [IOCTL_AW-1:0] base;
  } region_t;

  // Indexed by REGION_* encoding.
  localparam region_t REGION_TABLE [4] = '{
    '{27'h000_0000, 27'h002_0000, 27'h000_0000},  // main CPU
    '{27'h002_0000, 27'h000_8000, 27'h008_0000},  // sound CPU
    '{27'h002_8000, 27'h004_0000, 27'h010_0000},  // gfx
    '{27'h006_8000, 27'h000_0400, 27'h020_0000}   // PROM
  };

  // First address past a region.
  function automatic logic [IOCTL_AW-1:0] region_end(input region_t r);
    return r.start + r.size;
  endfunction

endpackage

// File: rtl/ioctl_region_decode.sv
// ioctl_region_decode
//   Combinational ROM address decoder against REGION_TABLE.
//   Ports:
//     addr   - ROM download byte address
//     region - matching REGION_* encoding
//     offset - addr minus the region start
//     ovf    - addr lies past the last region (region/offset then invalid)
module ioctl_region_decode
  import ioctl_loader_pkg::*;
(
  input  logic [IOCTL_AW-1:0] addr,
  output logic [1:0]          region,
  output logic [IOCTL_AW-1:0] offset,
  output logic                ovf
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves one unassigned, which would otherwise infer a latch.
    region = REGION_MAIN;
    offset = '0;
    ovf    = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (addr >= REGION_TABLE[i].start && addr < region_end(REGION_TABLE[i])) begin
        region = 2'(i);
        offset = addr - REGION_TABLE[i].start;
        ovf    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ioctl_loader_ctrl.sv
// ioctl_loader_ctrl
//   Sequences HPS ioctl downloads into the core. ROM bytes (index 0) are
//   decoded into one of four regions and forwarded over a req/ack memory
//   port with WAIT back-pressure; DIP-switch bytes (index 254) are captured
//   into o_DIPSW. Core reset is held until the ROM download completes.
//   Optional build macro IOCTL_LOADER_CHECKSUM_EN adds o_ROM_SUM, a 16-bit
//   wrapping sum of every ROM byte written to memory in the current download.
//   Ports:
//     i_HPSIO_CLK, i_RST_n            clock, async active-low reset
//     i_IOCTL_*                       HPS ioctl download interface
//     o_IOCTL_WAIT                    back-pressure to the HPS
//     o_MEM_REQ/ADDR/DATA/REGION      memory write request (held until ack)
//     i_MEM_ACK                       one-cycle memory acknowledge
//     o_DIPSW                         captured DIP bytes, byte n at [8n+7:8n]
//     o_ROM_LOADED, o_CORE_RST_n      load complete / core reset release
//     o_ERR_OVF                       sticky: ROM byte past the region map
module ioctl_loader_ctrl
  import ioctl_loader_pkg::*;
#(
  parameter int MEM_AW      = 22,
  parameter int DIPSW_BYTES = 8,
  parameter int WAIT_HOLD   = 2
) (
  input  logic                     i_HPSIO_CLK,
  input  logic                     i_RST_n,
  input  logic                     i_IOCTL_DOWNLOAD,
  input  logic [15:0]              i_IOCTL_INDEX,
  input  logic [26:0]              i_IOCTL_ADDR,
  input  logic [7:0]               i_IOCTL_DATA,
  input  logic                     i_IOCTL_WR,
  output logic                     o_IOCTL_WAIT,
  output logic                     o_MEM_REQ,
  output logic [MEM_AW-1:0]        o_MEM_ADDR,
  output logic [7:0]               o_MEM_DATA,
  output logic [1:0]               o_MEM_REGION,
  input  logic                     i_MEM_ACK,
  output logic [8*DIPSW_BYTES-1:0] o_DIPSW,
  output logic                     o_ROM_LOADED,
  output logic                     o_CORE_RST_n,
  output logic                     o_ERR_OVF
`ifdef IOCTL_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]              o_ROM_SUM
`endif
);

  localparam bit         HOLD_EN   = (WAIT_HOLD != 0);
  localparam logic [2:0] HOLD_INIT = HOLD_EN ? 3'(WAIT_HOLD - 1) : 3'd0;

  state_e state, state_nxt;

  logic                dl_q;
  logic                dl_rise, dl_fall;
  logic                fall_pend, fall_seen;
  logic [IOCTL_AW-1:0] lat_addr;
  logic [7:0]          lat_data;
  logic [2:0]          hold_cnt;
  logic                done_cnt;
  logic [7:0]          drop_cnt;
  logic                rom_start, enter_done, wr_dropped;

  logic [1:0]          dec_region;
  logic [IOCTL_AW-1:0] dec_offset;
  logic                dec_ovf;

  assign dl_rise   = i_IOCTL_DOWNLOAD & ~dl_q;
  assign dl_fall   = ~i_IOCTL_DOWNLOAD & dl_q;
  // A download end seen while a byte is in flight must still end the load.
  assign fall_seen = fall_pend | dl_fall;

  ioctl_region_decode u_decode (
    .addr   (lat_addr),
    .region (dec_region),
    .offset (dec_offset),
    .ovf    (dec_ovf)
  );

  always_ff @(posedge i_HPSIO_CLK or negedge i_RST_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_RST_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rom_start    = 1'b0;
    o_MEM_REQ    = 1'b0;
    o_IOCTL_WAIT = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dl_rise) begin
          if (i_IOCTL_INDEX == INDEX_ROM) begin
            state_nxt = ST_ROM_DL;
            rom_start = 1'b1;
          end else if (i_IOCTL_INDEX == INDEX_DIPSW) begin
            state_nxt = ST_DIP_DL;
          end
        end
      end
      ST_ROM_DL: begin
        if (i_IOCTL_WR)     state_nxt = ST_ROM_ISSUE;
        else if (fall_seen) state_nxt = ST_DONE;
      end
      ST_ROM_ISSUE: begin
        if (!dec_ovf)       state_nxt = ST_MEM_WAIT;
        else if (fall_seen) state_nxt = ST_DONE;
        else                state_nxt = ST_ROM_DL;
      end
      ST_MEM_WAIT: begin
        o_MEM_REQ    = 1'b1;
        o_IOCTL_WAIT = 1'b1;
        if (i_MEM_ACK) begin
          if (HOLD_EN)        state_nxt = ST_WAIT_HOLD;
          else if (fall_seen) state_nxt = ST_DONE;
          else                state_nxt = ST_ROM_DL;
        end
      end
      ST_WAIT_HOLD: begin
        o_IOCTL_WAIT = 1'b1;
        if (hold_cnt == 3'd0) state_nxt = fall_seen ? ST_DONE : ST_ROM_DL;
      end
      ST_DONE: begin
        if (done_cnt) state_nxt = ST_IDLE;
      end
      ST_DIP_DL: begin
        if (dl_fall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_done = (state_nxt == ST_DONE) && (state != ST_DONE);
  assign wr_dropped = i_IOCTL_WR &&
                      (state == ST_ROM_ISSUE || state == ST_MEM_WAIT || state == ST_WAIT_HOLD);

  // NOTE: the byte latch carries no reset; it is always written in ROM_DL
  // before ROM_ISSUE reads it, so its power-up value is never observed.
  always_ff @(posedge i_HPSIO_CLK) begin
    if (state == ST_ROM_DL && i_IOCTL_WR) begin
      lat_addr <= i_IOCTL_ADDR;
      lat_data <= i_IOCTL_DATA;
    end
  end

  always_ff @(posedge i_HPSIO_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      dl_q         <= 1'b0;
      fall_pend    <= 1'b0;
      hold_cnt     <= 3'd0;
      done_cnt     <= 1'b0;
      drop_cnt     <= 8'd0;
      o_MEM_ADDR   <= '0;
      o_MEM_DATA   <= 8'd0;
      o_MEM_REGION <= REGION_MAIN;
      o_DIPSW      <= '1;
      o_ROM_LOADED <= 1'b0;
      o_CORE_RST_n <= 1'b0;
      o_ERR_OVF    <= 1'b0;
    end else begin
      dl_q <= i_IOCTL_DOWNLOAD;

      if (state == ST_IDLE) fall_pend <= 1'b0;
      else if (dl_fall)     fall_pend <= 1'b1;

      if (state == ST_ROM_ISSUE) begin
        if (dec_ovf) begin
          o_ERR_OVF <= 1'b1;
        end else begin
          o_MEM_ADDR   <= MEM_AW'(REGION_TABLE[dec_region].base + dec_offset);
          o_MEM_REGION <= dec_region;
          o_MEM_DATA   <= lat_data;
        end
      end

      if (state == ST_MEM_WAIT && i_MEM_ACK) hold_cnt <= HOLD_INIT;
      else if (hold_cnt != 3'd0)             hold_cnt <= hold_cnt - 3'd1;

      // done_cnt reads 0 in the first DONE cycle and 1 in the second.
      done_cnt <= (state == ST_DONE);

      if (rom_start) begin
        o_ROM_LOADED <= 1'b0;
        o_ERR_OVF    <= 1'b0;
        o_CORE_RST_n <= 1'b0;
      end
      if (enter_done)                o_ROM_LOADED <= 1'b1;
      if (state == ST_DONE && done_cnt) o_CORE_RST_n <= 1'b1;

      // Protocol violations: a WR while the HPS should be stalled.
      if (wr_dropped && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (state == ST_DIP_DL && i_IOCTL_WR) begin
        for (int n = 0; n < DIPSW_BYTES; n++) begin
          if (i_IOCTL_ADDR == IOCTL_AW'(n)) o_DIPSW[8*n +: 8] <= i_IOCTL_DATA;
        end
      end
    end
  end

`ifdef IOCTL_LOADER_CHECKSUM_EN
  always_ff @(posedge i_HPSIO_CLK or negedge i_RST_n) begin
    if (!i_RST_n)                          o_ROM_SUM <= 16'd0;
    else if (rom_start)                    o_ROM_SUM <= 16'd0;
    else if (state == ST_MEM_WAIT && i_MEM_ACK) o_ROM_SUM <= o_ROM_SUM + {8'd0, o_MEM_DATA};
  end
`endif

endmodule

// File: doc/ioctl_loader_ctrl.md
Name: ioctl_loader_ctrl

Overview:
- Sequences HPS ioctl downloads into the core.
- ROM bytes (index 0) are decoded by address into one of four ROM regions. Each is forwarded to a shared memory write port over a req/ack handshake, with back-pressure to the HPS through o_IOCTL_WAIT.
- DIP-switch bytes (index 254) are captured into registers.
- Holds core reset until the ROM load completes and flags completion.

Parameters:
- MEM_AW, 22, memory write-port address width in bytes.
- DIPSW_BYTES, 8, number of DIP-switch bytes captured at index 254.
- WAIT_HOLD, 2, extra cycles o_IOCTL_WAIT stays high after i_MEM_ACK (range 0-7).

Ports:
- i_HPSIO_CLK  in  1  ioctl/memory clock.
- i_RST_n  in  1  asynchronous active-low reset.
- i_IOCTL_DOWNLOAD  in  1  download window active.
- i_IOCTL_INDEX  in  16  0 = ROM, 254 = DIP switches; any other value is ignored.
- i_IOCTL_ADDR  in  27  byte address within the download.
- i_IOCTL_DATA  in  8  byte data.
- i_IOCTL_WR  in  1  one-cycle write strobe.
- o_IOCTL_WAIT  out  1  back-pressure to the HPS.
- o_MEM_REQ  out  1  write request, level, held until ack.
- o_MEM_ADDR  out  MEM_AW  region base + offset.
- o_MEM_DATA  out  8  write byte.
- o_MEM_REGION  out  2  0 = main CPU, 1 = sound CPU, 2 = gfx, 3 = PROM.
- i_MEM_ACK  in  1  one-cycle acknowledge.
- o_DIPSW  out  8*DIPSW_BYTES  byte n at bits [8n+7:8n].
- o_ROM_LOADED  out  1  ROM download finished.
- o_CORE_RST_n  out  1  core reset, low until ROM is loaded.
- o_ERR_OVF  out  1  sticky: ROM address past end of the last region.

Behaviour:
- Reset: all outputs 0, except o_DIPSW = all 1s. State returns to IDLE. A pending request is dropped.
- Edge detection: i_IOCTL_DOWNLOAD is registered once.
- States:
  - IDLE: rising edge of download with index 0 -> ROM_DL; with index 254 -> DIP_DL; any other index stays in IDLE.
  - ROM_DL, on a WR strobe:
    - Latch addr/data and decode the region using the package table (start/size).
    - Drive o_MEM_ADDR = base + (addr - start), truncated to MEM_AW, on the following cycle.
    - Raise o_MEM_REQ and o_IOCTL_WAIT in the same cycle, then -> MEM_WAIT.
    - Address past the last region: set o_ERR_OVF, drop the byte, no request.
    - Falling edge of download -> DONE.
  - MEM_WAIT:
    - On i_MEM_ACK, drop o_MEM_REQ next cycle. Keep o_IOCTL_WAIT high WAIT_HOLD more cycles, then -> ROM_DL.
    - A download falling edge seen here is remembered; after ack -> DONE.
    - A WR strobe arriving while in MEM_WAIT violates protocol: count it as dropped and ignore it.
  - DONE: assert o_ROM_LOADED. Two cycles later release o_CORE_RST_n. -> IDLE.
  - DIP_DL:
    - WR with addr < DIPSW_BYTES writes byte addr; higher addresses are ignored. Never asserts o_IOCTL_WAIT.
    - Falling edge -> IDLE. o_ROM_LOADED is unaffected.
- Reload: a ROM download starting while o_ROM_LOADED=1 clears o_ROM_LOADED and o_ERR_OVF and drives o_CORE_RST_n low the next cycle.
- DIP downloads never touch core reset.
- Latency: WR strobe to o_MEM_REQ = 2 cycles.

Optional Feature:
- Macro IOCTL_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output o_ROM_SUM [15:0], cleared at ROM download start.
  - Adds the data byte (zero-extended, wrapping mod 2^16) on every accepted ROM byte, at ack time.
  - Overflow-dropped bytes are excluded.
- Undefined: port absent, no adder.

Decomposition:
- Package ioctl_loader_pkg holds:
  - the state enum;
  - INDEX_ROM = 16'd0 and INDEX_DIPSW = 16'd254;
  - the region typedef (start, size, base) and a 4-entry region table constant;
  - the REGION_* encodings.
- One sub-module, ioctl_region_decode: combinational; takes addr and returns region, offset and an overflow flag.

Test Plan:
- Reset with i_RST_n=0 mid-MEM_WAIT -> o_MEM_REQ=0 and o_IOCTL_WAIT=0 immediately (asynchronous); o_DIPSW=all FF; o_CORE_RST_n=0.
- ROM write addr 0x0, data 0xA5; ack after 3 cycles:
  - o_MEM_REQ 2 cycles after WR, region 0, o_MEM_ADDR=0x0, data 0xA5;
  - o_IOCTL_WAIT high from request until ack+WAIT_HOLD.
- Write at the first gfx-region address -> o_MEM_REGION=2, o_MEM_ADDR = gfx base + 0. Address beyond the table -> no request, o_ERR_OVF=1.
- Index 254 writes 0xAF, 0xFC at addr 0,1, plus addr 9 -> o_DIPSW[15:0]=0xFCAF, upper bytes remain 0xFF, o_IOCTL_WAIT never high.
- Download falls during MEM_WAIT -> ack completes the write; o_ROM_LOADED=1; o_CORE_RST_n rises 2 cycles later. A second ROM download drops both low again.
- With IOCTL_LOADER_CHECKSUM_EN: bytes 0xFF, 0x02, 0x10 -> o_ROM_SUM=0x0111.
